// File: rtl/alu_driver.sv
// alu_driver: runs one instruction at a time through read, external ALU execute and writeback
//   clk, reset          : clock, synchronous active-high reset
//   instr_*             : valid/ready instruction handshake and instruction fields
//   alu_a/b/opcode/cin  : operands, opcode and carry-in for the external ALU
//   alu_c, alu_flags    : ALU result and flags {C,L,F,Z,N}
//   psr, done, illegal  : status register, retire pulse, illegal-opcode pulse
//   dbg_addr, dbg_data  : combinational register-file read port
module alu_driver #(
  parameter int NREG = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        instr_valid,
  output logic        instr_ready,
  input  logic [4:0]  instr_op,
  input  logic [3:0]  instr_rdest,
  input  logic [3:0]  instr_rsrc,
  input  logic [15:0] instr_imm,
  input  logic        instr_imm_sel,
  output logic [15:0] alu_a,
  output logic [15:0] alu_b,
  output logic [4:0]  alu_opcode,
  output logic        alu_cin,
  input  logic [15:0] alu_c,
  input  logic [4:0]  alu_flags,
  output logic [4:0]  psr,
  output logic        done,
  output logic        illegal,
  input  logic [3:0]  dbg_addr,
  output logic [15:0] dbg_data
);
  localparam logic [4:0] ADD = 5'b00101, ADDU = 5'b00110, ADDC = 5'b00111, ADDCU = 5'b01111;
  localparam logic [4:0] SUB = 5'b01001, CMP = 5'b01011, AND = 5'b00001, OR = 5'b00010;
  localparam logic [4:0] XOR = 5'b00011, NOT = 5'b00100, LSH = 5'b01100, RSH = 5'b10011;
  localparam logic [4:0] ARSH = 5'b10111;
  typedef enum logic [1:0] {IDLE, READ, EXEC, WRITE} state_t;
  state_t      state;
  logic [15:0] regs [NREG];
  logic [4:0]  op, flags;
  logic [3:0]  rdest, rsrc;
  logic [15:0] imm, res;
  logic        imm_sel, legal, psr_ld;
  assign legal = op inside {ADD, ADDU, ADDC, ADDCU, SUB, CMP, AND, OR, XOR, NOT, LSH, RSH, ARSH};
  assign psr_ld = op inside {ADD, ADDC, SUB, CMP};
  assign instr_ready = state == IDLE;
  assign dbg_data = regs[dbg_addr];
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      psr        <= '0;
      done       <= 1'b0;
      illegal    <= 1'b0;
      alu_a      <= '0;
      alu_b      <= '0;
      alu_opcode <= '0;
      alu_cin    <= 1'b0;
      op         <= '0;
      rdest      <= '0;
      rsrc       <= '0;
      imm        <= '0;
      imm_sel    <= 1'b0;
      res        <= '0;
      flags      <= '0;
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else begin
      done    <= 1'b0;
      illegal <= 1'b0;
      case (state)
        IDLE: if (instr_valid) begin
          op      <= instr_op;
          rdest   <= instr_rdest;
          rsrc    <= instr_rsrc;
          imm     <= instr_imm;
          imm_sel <= instr_imm_sel;
          state   <= READ;
        end
        // ALU outputs are loaded here so they are stable throughout EXEC and hold afterwards
        READ: begin
          alu_a      <= regs[rdest];
          alu_b      <= imm_sel ? imm : regs[rsrc];
          alu_opcode <= op;
          alu_cin    <= psr[4];
          state      <= EXEC;
        end
        // done/illegal are registered here so they pulse during WRITE
        EXEC: begin
          res     <= alu_c;
          flags   <= alu_flags;
          done    <= 1'b1;
          illegal <= !legal;
          state   <= WRITE;
        end
        WRITE: begin
          if (legal && op != CMP) regs[rdest] <= res;
          if (psr_ld) psr <= flags;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_alu_driver.sv
// tb_alu_driver: directed vectors with a queue scoreboard and an external ALU stand-in
module tb_alu_driver;
  localparam logic [4:0] ADD = 5'b00101, ADDU = 5'b00110, ADDC = 5'b00111, ADDCU = 5'b01111;
  localparam logic [4:0] SUB = 5'b01001, CMP = 5'b01011, AND = 5'b00001, OR = 5'b00010;
  localparam logic [4:0] XOR = 5'b00011, NOT = 5'b00100, LSH = 5'b01100, RSH = 5'b10011;
  localparam logic [4:0] ARSH = 5'b10111, BAD = 5'b11111;
  logic        clk = 1'b0, reset = 1'b1, instr_valid = 1'b0, instr_ready, instr_imm_sel = 1'b0;
  logic [4:0]  instr_op = '0, alu_opcode, alu_flags, psr;
  logic [3:0]  instr_rdest = '0, instr_rsrc = '0, dbg_addr = '0;
  logic [15:0] instr_imm = '0, alu_a, alu_b, alu_c, dbg_data;
  logic        alu_cin, done, illegal;
  logic [5:0]  q[$];
  int          checks = 0, failures = 0, done_cnt = 0, issued = 0;
  always #5 clk = ~clk;
  alu_driver dut (
    .clk(clk), .reset(reset), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr_op(instr_op), .instr_rdest(instr_rdest), .instr_rsrc(instr_rsrc),
    .instr_imm(instr_imm), .instr_imm_sel(instr_imm_sel), .alu_a(alu_a), .alu_b(alu_b),
    .alu_opcode(alu_opcode), .alu_cin(alu_cin), .alu_c(alu_c), .alu_flags(alu_flags),
    .psr(psr), .done(done), .illegal(illegal), .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );
  // external ALU: flags {C,L,F,Z,N}
  always_comb begin
    logic [16:0] s;
    s = '0;
    alu_c = '0;
    alu_flags = '0;
    case (alu_opcode)
      ADD, ADDU, ADDC, ADDCU: begin
        s = {1'b0, alu_a} + {1'b0, alu_b} + {16'd0, (alu_opcode == ADDC || alu_opcode == ADDCU) && alu_cin};
        alu_c = s[15:0];
        alu_flags = {s[16], 1'b0, alu_a[15] == alu_b[15] && s[15] != alu_a[15], s[15:0] == 0, s[15]};
      end
      SUB: begin
        alu_c = alu_a - alu_b;
        alu_flags = {alu_a < alu_b, 1'b0, alu_a[15] != alu_b[15] && alu_c[15] != alu_a[15], alu_c == 0, alu_c[15]};
      end
      CMP: begin
        alu_c = alu_a;
        alu_flags = {1'b0, alu_b > alu_a, 1'b0, alu_a == alu_b, $signed(alu_b) > $signed(alu_a)};
      end
      AND: alu_c = alu_a & alu_b;
      OR: alu_c = alu_a | alu_b;
      XOR: alu_c = alu_a ^ alu_b;
      NOT: alu_c = ~alu_a;
      LSH: alu_c = alu_a << alu_b[3:0];
      RSH: alu_c = alu_a >> alu_b[3:0];
      ARSH: alu_c = $unsigned($signed(alu_a) >>> alu_b[3:0]);
      default: alu_c = '0;
    endcase
    if (alu_opcode inside {AND, OR, XOR, NOT, LSH, RSH, ARSH}) alu_flags = {3'b000, alu_c == 0, alu_c[15]};
  end
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic chk_reg(input logic [3:0] a, input logic [15:0] e);
    dbg_addr = a;
    #1;
    chk($sformatf("r%0d", a), dbg_data, e);
  endtask
  task automatic issue(input logic [4:0] op, input logic [3:0] rd, input logic [3:0] rs,
                       input logic [15:0] im, input logic sel, input logic [4:0] ep,
                       input logic eill, input logic hold);
    int n;
    @(negedge clk);
    instr_op = op;
    instr_rdest = rd;
    instr_rsrc = rs;
    instr_imm = im;
    instr_imm_sel = sel;
    instr_valid = 1'b1;
    chk("ready_idle", instr_ready, 1);
    q.push_back({eill, ep});
    issued++;
    @(posedge clk);
    #1 instr_valid = hold;
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (n == 1) chk("ready_busy", instr_ready, 0);
      if (n == 2) chk("exec_opcode", alu_opcode, op);
      if (n == 2 && op == ADDC) chk("exec_cin", alu_cin, 1);
    end while (!done && n < 8);
    chk("latency", n, 3);
    instr_valid = 1'b0;
    @(negedge clk);
  endtask
  // monitor: pops an expectation on every done pulse; psr is visible the cycle after WRITE
  initial begin
    logic [5:0] e;
    forever begin
      @(negedge clk);
      if (done) begin
        done_cnt++;
        if (q.size() == 0) begin
          chk("unexpected_done", done, 0);
        end else begin
          e = q.pop_front();
          chk("illegal", illegal, e[5]);
          @(negedge clk);
          chk("psr", psr, e[4:0]);
        end
      end
    end
  end
  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end
  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    chk("rst_ready", instr_ready, 1);
    chk("rst_psr", psr, 0);
    chk("rst_done", done, 0);
    chk("rst_illegal", illegal, 0);
    chk("rst_alu_a", alu_a, 0);
    chk("rst_alu_b", alu_b, 0);
    chk("rst_alu_opcode", alu_opcode, 0);
    chk("rst_alu_cin", alu_cin, 0);
    chk_reg(0, 16'h0000);
    issue(ADDU, 1, 0, 16'h7FFF, 1, 5'h00, 0, 0);
    chk_reg(1, 16'h7FFF);
    issue(ADD, 1, 0, 16'h0001, 1, 5'h05, 0, 0);
    chk_reg(1, 16'h8000);
    issue(ADDU, 2, 0, 16'hFFFF, 1, 5'h05, 0, 0);
    issue(ADD, 2, 0, 16'h0001, 1, 5'h12, 0, 0);
    chk_reg(2, 16'h0000);
    issue(ADDC, 3, 0, 16'h0000, 1, 5'h00, 0, 0);
    chk_reg(3, 16'h0001);
    issue(ADDU, 4, 0, 16'h0005, 1, 5'h00, 0, 0);
    issue(ADDU, 5, 0, 16'h0007, 1, 5'h00, 0, 0);
    issue(CMP, 4, 5, 16'h0000, 0, 5'h09, 0, 0);
    chk_reg(4, 16'h0005);
    issue(AND, 4, 5, 16'h0000, 0, 5'h09, 0, 0);
    chk_reg(4, 16'h0005);
    issue(ADDU, 6, 0, 16'h8000, 1, 5'h09, 0, 0);
    issue(ARSH, 6, 0, 16'h0004, 1, 5'h09, 0, 0);
    chk_reg(6, 16'hF800);
    issue(ADDU, 8, 0, 16'h8000, 1, 5'h09, 0, 0);
    issue(RSH, 8, 0, 16'h0004, 1, 5'h09, 0, 0);
    chk_reg(8, 16'h0800);
    issue(BAD, 4, 5, 16'h1111, 1, 5'h09, 1, 1);
    chk_reg(4, 16'h0005);
    issue(ADD, 5, 5, 16'h0000, 0, 5'h00, 0, 0);
    chk_reg(5, 16'h000E);
    issue(SUB, 5, 0, 16'h000E, 1, 5'h02, 0, 0);
    chk_reg(5, 16'h0000);
    issue(ADDU, 0, 0, 16'hABCD, 1, 5'h02, 0, 0);
    chk_reg(0, 16'hABCD);
    @(negedge clk);
    instr_op = ADD;
    instr_rdest = 7;
    instr_imm = 16'h1234;
    instr_imm_sel = 1'b1;
    instr_valid = 1'b1;
    @(posedge clk);
    #1 instr_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("midrst_ready", instr_ready, 1);
    chk("midrst_psr", psr, 0);
    chk("midrst_done", done, 0);
    chk("midrst_alu_a", alu_a, 0);
    chk("midrst_alu_opcode", alu_opcode, 0);
    chk_reg(7, 16'h0000);
    chk_reg(1, 16'h0000);
    repeat (5) @(negedge clk);
    chk_reg(7, 16'h0000);
    instr_op = ADDU;
    instr_rdest = 9;
    instr_imm = 16'h0001;
    instr_valid = 1'b1;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    instr_valid = 1'b0;
    repeat (5) @(negedge clk);
    chk("rsths_ready", instr_ready, 1);
    chk_reg(9, 16'h0000);
    issue(ADDU, 9, 0, 16'h0042, 1, 5'h00, 0, 0);
    chk_reg(9, 16'h0042);
    repeat (3) @(negedge clk);
    chk("done_count", done_cnt, issued);
    chk("queue_empty", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/alu_driver.md
ALU_DRIVER -- requirements
Module: alu_driver

Interface
REQ-001 Parameter NREG, default 16, number of 16-bit registers in the register file (must be 16; address width fixed at 4).
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 instr_valid  input  1  instruction offered this cycle.
REQ-005 instr_ready  output  1  block can accept an instruction this cycle.
REQ-006 instr_op  input  5  ALU opcode (ADD 00101, ADDU 00110, ADDC 00111, ADDCU 01111, SUB 01001, CMP 01011, AND 00001, OR 00010, XOR 00011, NOT 00100, LSH 01100, RSH 10011, ARSH 10111).
REQ-007 instr_rdest  input  4  destination register; also source for ALU operand A.
REQ-008 instr_rsrc  input  4  source register for operand B when instr_imm_sel=0.
REQ-009 instr_imm  input  16  immediate for operand B when instr_imm_sel=1.
REQ-010 instr_imm_sel  input  1  operand B select.
REQ-011 alu_a, alu_b  output  16 each  operands to the external combinational ALU.
REQ-012 alu_opcode  output  5  opcode to the ALU.
REQ-013 alu_cin  output  1  carry-in to the ALU.
REQ-014 alu_c  input  16  ALU result.
REQ-015 alu_flags  input  5  ALU flags {C,L,F,Z,N} = bits [4:0].
REQ-016 psr  output  5  processor status register, same bit order as alu_flags.
REQ-017 done  output  1  one-cycle pulse when an instruction retires.
REQ-018 illegal  output  1  one-cycle pulse, coincident with done, when the retired opcode is not in REQ-006.
REQ-019 dbg_addr  input  4; dbg_data  output  16  combinational register-file read port.

Function
REQ-020 FSM states IDLE, READ, EXEC, WRITE; one instruction in flight at a time.
REQ-021 instr_ready SHALL be 1 only in IDLE; handshake completes when instr_valid & instr_ready at a rising edge; fields are latched then; IDLE->READ.
REQ-022 READ: latch A=reg[rdest], B = imm_sel ? imm : reg[rsrc], opcode; READ->EXEC unconditionally.
REQ-023 EXEC: alu_a/alu_b/alu_opcode driven from latched values; alu_cin = psr[4]; at the end of EXEC capture alu_c and alu_flags; EXEC->WRITE.
REQ-024 Outside EXEC, alu_a, alu_b and alu_opcode SHALL hold their last driven values (0 after reset).
REQ-025 WRITE: reg[rdest] <= captured result for all legal opcodes except CMP; WRITE->IDLE; done=1 this cycle.
REQ-026 PSR SHALL be loaded with captured flags in WRITE only for ADD, ADDC, SUB, CMP; all other opcodes leave PSR unchanged.
REQ-027 Illegal opcode: no register write, no PSR update, done=1 and illegal=1 in WRITE.
REQ-028 Latency: handshake edge at cycle 0, done high in cycle 3, instr_ready high again in cycle 4; throughput one instruction per 4 cycles.
REQ-029 rdest==rsrc is legal; both operands read the same pre-instruction value.
REQ-030 Register write in WRITE is visible on dbg_data the following cycle; all 16 registers writable, including r0.
REQ-031 instr_valid asserted while not ready is ignored and SHALL NOT alter state.

Reset
REQ-032 reset asserted at a rising edge SHALL, in any state including mid-instruction, force IDLE, clear psr, done, illegal, alu_a, alu_b, alu_opcode, alu_cin, and all registers to 0; the in-flight instruction is discarded with no write.
REQ-033 reset has priority over a simultaneous handshake; the offered instruction is not accepted.

Verification
REQ-034 Load r1=0x7FFF (ADDU r1,imm 0x7FFF from 0), ADD r1,imm 0x0001 -> r1=0x8000, psr F=1 N=1 Z=0 C=0, done in cycle 3 after handshake.
REQ-035 r2=0xFFFF, ADD r2,imm 0x0001 -> r2=0x0000, psr C=1 Z=1; then ADDC r3(=0),imm 0 -> r3=0x0001 (alu_cin=1 observed in EXEC).
REQ-036 r4=0x0005, r5=0x0007, CMP r4,r5 -> r4 unchanged 0x0005, psr N=1 L=1 Z=0; then AND r4,r5 -> r4=0x0005, psr unchanged.
REQ-037 r6=0x8000, ARSH r6,imm 0x0004 -> r6=0xF800; RSH from 0x8000 by 4 -> 0x0800; psr unchanged.
REQ-038 Opcode 11111 -> done=1, illegal=1, no register or psr change; instr_valid held high during EXEC -> ignored.
REQ-039 reset asserted in EXEC of ADD r7,imm 0x1234 -> next cycle IDLE, instr_ready=1, r7=0, psr=0, no done pulse.
